gray_seq_ctrl: RTL and testbench
================================

# gray_seq_ctrl

Sequencing controller for the team's Gray-code counter datapath. It accepts a run command with a step count and a direction, then steps an internal binary count register once per enabled cycle. The Gray encoding is published on `gray_out`. The block handles pause, clear, busy and done signalling so a higher-level FSM can issue counted Gray sequences without tracking the counter itself. It sits between the system control logic and any consumer of the Gray-coded count.

## Interface
- `WIDTH`, default 4: width of the count and the Gray output.
- `STEP_W`, default 8: width of the step-count command; allows runs longer than one wrap.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1  run command; accepted only in IDLE.
- `steps`  in  STEP_W  number of count steps for the run; sampled with `start`.
- `dir`  in  1  0 = up (+1), 1 = down (−1); sampled with `start`.
- `pause`  in  1  holds the count while in RUN.
- `clr`  in  1  zeroes the count; honoured only in IDLE.
- `gray_out`  out  WIDTH  Gray code of the count: `bin ^ (bin >> 1)`; registered.
- `bin_out`  out  WIDTH  binary count register.
- `busy`  out  1  high while in RUN.
- `step`  out  1  high in each cycle in which `gray_out` has just changed.
- `done`  out  1  one-cycle pulse after the final step of a run.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `start` = 1 and `steps` ≠ 0: latch `steps` into `remaining` and latch `dir`; go to RUN.
  - `start` = 1 and `steps` = 0: go to DONE; the count is unchanged.
  - `clr` = 1 without `start`: `bin` ← 0.
  - `clr` and `start` in the same cycle: `start` wins and `clr` is ignored.
- **RUN**
  - `pause` = 0:
    - `bin` ← `bin` ± 1, modulo 2^WIDTH.
    - `remaining` ← `remaining` − 1.
    - `step` = 1 in the following cycle.
    - When the decremented `remaining` equals 0, go to DONE.
  - `pause` = 1: all registers hold and `step` = 0.
  - `start` and `clr` are ignored.
- **DONE**
  - `done` = 1 for exactly one cycle.
  - Go to IDLE unconditionally.
  - `start` is ignored in this state.
- The count persists across runs. A new run continues from the current `bin`; only `clr` or `reset` zeroes it.
- Wrap-around is modular in both directions:
  - Up: 2^WIDTH−1 → 0 (for WIDTH = 4, Gray 1000 → 0000).
  - Down: 0 → 2^WIDTH−1 (Gray 0000 → 1000).
- Every `step` cycle shows exactly one changed bit in `gray_out` versus the previous value. This is a mandatory assertion.
- Reset mid-run aborts the run. All registers return to their reset values, and no `done` pulse is produced for the aborted run.

## Timing
- Reset values:
  - State IDLE.
  - `bin_out` = 0, `gray_out` = 0.
  - `busy` = 0, `step` = 0, `done` = 0.
  - `remaining` = 0.
- Run with N steps, `start` sampled at edge k, no pause:
  - `busy` is high from edge k to edge k+N (N cycles).
  - `bin` and `gray_out` update at edges k+1 … k+N.
  - `step` is high in the cycles after edges k+1 … k+N.
  - `done` is high in the cycle after edge k+N+1. Total latency from start to done = N+1 edges.
- Each pause cycle in RUN adds one cycle to `busy` and to the done latency.
- `steps` = 0: `done` is high in the cycle after edge k+1; `busy` never asserts.
- The next `start` is accepted at the earliest at edge k+N+2, in IDLE.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
1. **Reset:** hold `reset` for 2 cycles. Required: `gray_out` = 0000, `bin_out` = 0, `busy` = 0, `step` = 0, `done` = 0.
2. **Up run:** `start`, `steps` = 5, `dir` = 0 from 0. Required: `gray_out` sequence 0001, 0011, 0010, 0110, 0111 on 5 consecutive edges; `busy` high 5 cycles; one `done` pulse; `bin_out` = 5.
3. **Wrap both ways:** `start`, `steps` = 20, `dir` = 0 from 0. Required: Gray 1000 → 0000 is seen at the wrap; final `bin_out` = 4 and `gray_out` = 0110. Then `steps` = 5, `dir` = 1. Required: `bin_out` = 15 and `gray_out` = 1000.
4. **Pause:** run with `steps` = 4 and `pause` high for 2 cycles after the second step. Required: `gray_out` holds for those 2 cycles with `step` = 0; `busy` lasts 6 cycles; the single-bit-change assertion never fires.
5. **Zero steps, clr, ignored start:**
   - `steps` = 0: `done` one cycle after `start`; `busy` stays 0.
   - `clr` in IDLE with `bin_out` = 7: `bin_out` = 0.
   - `start` pulsed during RUN: no effect on the run.
6. **Reset mid-run:** assert `reset` on the 3rd step of a 10-step run. Required: all outputs 0 on the next edge; no `done` pulse; a following `start` with `steps` = 1 gives `gray_out` = 0001.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// Counted Gray-code sequencer. It steps a binary count up or down once per
// un-paused RUN cycle and publishes the registered Gray encoding.
module gray_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] steps,
    input  logic              dir,
    input  logic              pause,
    input  logic              clr,
    output logic [WIDTH-1:0]  gray_out,
    output logic [WIDTH-1:0]  bin_out,
    output logic              busy,
    output logic              step,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [WIDTH-1:0]    gray_q, gray_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                dir_q, dir_d;
    logic                busy_q, busy_d;
    logic                step_q, step_d;
    logic                done_q, done_d;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (steps != '0) begin
                        rem_d   = steps;
                        dir_d   = dir;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (clr) begin
                    bin_d = '0;
                end
            end
            S_RUN: begin
                if (!pause) begin
                    bin_d  = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
                    rem_d  = rem_q - STEP_W'(1);
                    step_d = 1'b1;
                    if (rem_q == STEP_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Registered below, so the pulse lands one cycle after DONE.
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        gray_d = bin_d ^ (bin_d >> 1);
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign gray_out = gray_q;
    assign bin_out  = bin_q;
    assign busy     = busy_q;
    assign step     = step_q;
    assign done     = done_q;

    // A Gray step must flip exactly one output bit.
    assert property (@(posedge clk) disable iff (reset)
        step_q |-> ($countones(gray_q ^ $past(gray_q)) == 1));

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Randomized scoreboard bench for gray_seq_ctrl. The stimulus pushes expected
// step/done values, and a negedge monitor pops them and compares.
module tb_gray_seq_ctrl;

    localparam int W  = 4;
    localparam int SW = 8;
    localparam int M  = (1 << W) - 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [SW-1:0] steps;
    logic          dir;
    logic          pause;
    logic          clr;
    logic [W-1:0]  gray_out;
    logic [W-1:0]  bin_out;
    logic          busy;
    logic          step;
    logic          done;

    gray_seq_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .steps    (steps),
        .dir      (dir),
        .pause    (pause),
        .clr      (clr),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .busy     (busy),
        .step     (step),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int model_bin;
    int exp_step_q[$];
    int exp_done_q[$];
    int busy_cnt;
    bit wrap_up_seen;
    bit wrap_dn_seen;
    logic [W-1:0] prev_gray;
    int mon_e;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gray_of(input int b);
        return (b ^ (b >> 1)) & M;
    endfunction

    // Monitor: compares every step and done the DUT presents with the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (step) begin
                if (exp_step_q.size() == 0) begin
                    check(1'b0, "unexpected_step", int'(bin_out), -1);
                end else begin
                    mon_e = exp_step_q.pop_front();
                    check(bin_out == mon_e, "step_bin", int'(bin_out), mon_e);
                    check(gray_out == gray_of(mon_e), "step_gray", int'(gray_out), gray_of(mon_e));
                    $display("step bin=%0d gray=%b", bin_out, gray_out);
                end
                check($countones(gray_out ^ prev_gray) == 1, "one_bit_change",
                      int'(gray_out), int'(prev_gray));
                if (prev_gray == 4'b1000 && gray_out == 4'b0000) wrap_up_seen = 1'b1;
                if (prev_gray == 4'b0000 && gray_out == 4'b1000) wrap_dn_seen = 1'b1;
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    check(1'b0, "unexpected_done", int'(bin_out), -1);
                end else begin
                    mon_e = exp_done_q.pop_front();
                    check(bin_out == mon_e, "done_bin", int'(bin_out), mon_e);
                    $display("done bin=%0d", bin_out);
                end
            end
            if (busy) busy_cnt++;
        end
        prev_gray = gray_out;
    end

    // One run command: n steps, direction d, optional pause of p_len cycles
    // after step p_at, and optional ignored start/clr pokes.
    task automatic do_run(input int n, input bit d, input int p_at, input int p_len, input bit poke);
        int lat;
        int pl;
        for (int i = 1; i <= n; i++) begin
            model_bin = d ? ((model_bin - 1) & M) : ((model_bin + 1) & M);
            exp_step_q.push_back(model_bin);
        end
        exp_done_q.push_back(model_bin);
        pl = (n >= 2 && p_len > 0 && p_at >= 1 && p_at < n) ? p_len : 0;
        busy_cnt = 0;
        start = 1'b1;
        steps = SW'(n);
        dir   = d;
        clr   = poke;
        @(posedge clk); #1;
        start = 1'b0;
        clr   = 1'b0;
        lat   = 0;
        for (int j = 1; j <= n + pl + 10 && lat == 0; j++) begin
            @(posedge clk); #1;
            start = 1'b0;
            clr   = 1'b0;
            pause = (pl > 0 && j >= p_at && j < p_at + pl);
            if (poke && n >= 3 && j == 2) begin
                start = 1'b1;
                steps = SW'($urandom_range(1, 30));
                dir   = ~d;
                clr   = 1'b1;
            end
            if (poke && n > 0 && j == n + pl) begin
                start = 1'b1;
                steps = SW'($urandom_range(1, 9));
                dir   = $urandom_range(0, 1);
            end
            if (done) lat = j;
        end
        start = 1'b0;
        clr   = 1'b0;
        pause = 1'b0;
        check(lat == n + pl + 1, "done_latency", lat, n + pl + 1);
        check(busy_cnt == ((n == 0) ? 0 : n + pl), "busy_cycles", busy_cnt, (n == 0) ? 0 : n + pl);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check(exp_step_q.size() == 0, "steps_left", exp_step_q.size(), 0);
        check(exp_done_q.size() == 0, "done_left", exp_done_q.size(), 0);
        check(bin_out == model_bin, "final_bin", int'(bin_out), model_bin);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_bin = 0;
        check(bin_out == 0, "clr_bin", int'(bin_out), 0);
        check(gray_out == 0, "clr_gray", int'(gray_out), 0);
    endtask

    initial begin
        int n, pa, pln;
        bit dn_done;
        reset = 1'b1;
        start = 1'b0;
        steps = '0;
        dir   = 1'b0;
        pause = 1'b0;
        clr   = 1'b0;
        model_bin = 0;
        repeat (2) @(posedge clk);
        #1;
        check(gray_out == 0, "rst_gray", int'(gray_out), 0);
        check(bin_out == 0, "rst_bin", int'(bin_out), 0);
        check(busy == 0, "rst_busy", int'(busy), 0);
        check(step == 0, "rst_step", int'(step), 0);
        check(done == 0, "rst_done", int'(done), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_run(5, 1'b0, 0, 0, 1'b0);
        check(bin_out == 5, "up5_bin", int'(bin_out), 5);
        check(gray_out == 4'b0111, "up5_gray", int'(gray_out), 7);

        do_clr();
        wrap_up_seen = 1'b0;
        do_run(20, 1'b0, 0, 0, 1'b0);
        check(wrap_up_seen, "wrap_up", int'(wrap_up_seen), 1);
        check(bin_out == 4 && gray_out == 4'b0110, "wrap20_gray", int'(gray_out), 6);
        wrap_dn_seen = 1'b0;
        do_run(5, 1'b1, 0, 0, 1'b0);
        check(wrap_dn_seen, "wrap_down", int'(wrap_dn_seen), 1);
        check(bin_out == 15 && gray_out == 4'b1000, "down5_gray", int'(gray_out), 8);

        do_run(4, 1'b0, 2, 2, 1'b0);
        do_run(0, 1'b0, 0, 0, 1'b0);
        do_clr();
        do_run(7, 1'b0, 0, 0, 1'b0);
        check(bin_out == 7, "pre_clr_bin", int'(bin_out), 7);
        do_clr();
        do_run(8, 1'b0, 0, 0, 1'b1);

        // Reset mid-run: the run aborts with no done pulse.
        exp_step_q.push_back((model_bin + 1) & M);
        start = 1'b1;
        steps = SW'(10);
        dir   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_step_q.delete();
        exp_done_q.delete();
        model_bin = 0;
        @(posedge clk); #1;
        check(bin_out == 0 && gray_out == 0, "midrst_count", int'(bin_out), 0);
        check(busy == 0 && step == 0 && done == 0, "midrst_flags", int'({busy, step, done}), 0);
        reset = 1'b0;
        dn_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dn_done = 1'b1;
        end
        check(!dn_done, "midrst_no_done", int'(dn_done), 0);
        do_run(1, 1'b0, 0, 0, 1'b0);
        check(gray_out == 4'b0001, "after_rst_gray", int'(gray_out), 1);

        for (int it = 0; it < 20; it++) begin
            n   = $urandom_range(0, 40);
            pa  = 0;
            pln = 0;
            if (n >= 2 && $urandom_range(0, 1) == 1) begin
                pa  = $urandom_range(1, n - 1);
                pln = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 4) == 0) do_clr();
            do_run(n, 1'(($urandom_range(0, 1))), pa, pln, 1'(($urandom_range(0, 1))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
